// File: rtl/pe_ran_scheduler.sv
// pe_ran_scheduler: job sequencer for one PEran processing element.
// Streams parent words through the PE and writes results to child memory.
module pe_ran_scheduler #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 11,
    parameter int PE_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [ADDR_W-1:0] wr_base,
    input  logic [CNT_W-1:0]  num_words,
    input  logic [159:0]      matrix_in,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic [31:0]       pe_nucl,
    output logic [159:0]      pe_matrix,
    input  logic [31:0]       pe_result,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    input  logic              wr_ready
);

    localparam int WAIT_W = (PE_LAT < 2) ? 1 : $clog2(PE_LAT + 1);
    localparam logic [WAIT_W-1:0] LAT = WAIT_W'(PE_LAT);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPT,
        PEWAIT,
        WRITE,
        FIN
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   words_left;
    logic [WAIT_W-1:0]  wait_cnt;

    // Job FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            pe_nucl    <= '0;
            pe_matrix  <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            words_left <= '0;
            wait_cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                // Cancel drops any pending write and suppresses done.
                state <= IDLE;
                busy  <= 1'b0;
                rd_en <= 1'b0;
                wr_en <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            rd_addr    <= rd_base;
                            wr_addr    <= wr_base;
                            words_left <= num_words;
                            pe_matrix  <= matrix_in;
                            busy       <= 1'b1;
                            if (num_words == '0) begin
                                state <= FIN;
                            end else begin
                                state <= READ;
                                rd_en <= 1'b1;
                            end
                        end
                    end
                    READ: begin
                        rd_en <= 1'b0;
                        state <= CAPT;
                    end
                    CAPT: begin
                        pe_nucl  <= rd_data;
                        wait_cnt <= LAT;
                        state    <= PEWAIT;
                    end
                    PEWAIT: begin
                        if (wait_cnt == WAIT_W'(1)) begin
                            wait_cnt <= '0;
                            wr_data  <= pe_result;
                            wr_en    <= 1'b1;
                            state    <= WRITE;
                        end else begin
                            wait_cnt <= wait_cnt - WAIT_W'(1);
                        end
                    end
                    WRITE: begin
                        if (wr_ready) begin
                            wr_en      <= 1'b0;
                            words_left <= words_left - CNT_W'(1);
                            rd_addr    <= rd_addr + ADDR_W'(1);
                            wr_addr    <= wr_addr + ADDR_W'(1);
                            if (words_left == CNT_W'(1)) begin
                                state <= FIN;
                            end else begin
                                state <= READ;
                                rd_en <= 1'b1;
                            end
                        end
                    end
                    FIN: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        rd_en <= 1'b0;
                        wr_en <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
